// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
// Contents: opcode constants, NOP word, default reset PC, fetch state encoding,
// and the J-type target helper.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

  // J-type destination: upper nibble of PC+4, 26-bit index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for an instruction word and its PC+4.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_load                capture i_instr/i_pc4, mark valid
//   i_drain               entry consumed, mark empty
//   i_flush               discard entry (wins over load/drain)
//   i_instr, i_pc4        data to capture
//   o_valid, o_instr, o_pc4  buffered entry
module fetch_skid (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, issues instruction-memory requests,
// holds the IF/ID register with a one-entry skid buffer, applies branch/jump redirects.
// Ports:
//   clk, rst                       clock, async active-high reset
//   imem_req, imem_addr            fetch request / address (= pc)
//   imem_rdata, imem_ready         returned word, completes the current address
//   stall                          downstream cannot take if_instr this cycle
//   branch_taken, branch_target    redirect pulse from EX
//   jump                           decoder Jump bit for if_instr
//   if_valid, if_instr, if_pc4     IF/ID register
//   op                             if_instr[31:26] to the control decoder
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc4,
  output logic [5:0]        op
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_if_valid, w_if_valid_nxt;
  logic [31:0]  r_if_instr, w_if_instr_nxt;
  logic [31:0]  r_if_pc4, w_if_pc4_nxt;

  logic [31:0]  w_pc4;
  logic         w_jump_eff;
  logic         w_redirect;
  logic [31:0]  w_target;

  logic         w_skid_load, w_skid_drain, w_skid_flush;
  logic         w_skid_valid;
  logic [31:0]  w_skid_instr, w_skid_pc4;

  // Wraps modulo 2^32 by construction.
  assign w_pc4      = r_pc + 32'd4;
  assign w_jump_eff = jump && r_if_valid && !stall;
  assign w_redirect = branch_taken || w_jump_eff;
  assign w_target   = branch_taken ? branch_target : jump_target(r_if_pc4, r_if_instr);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc4_nxt   = r_if_pc4;
    w_skid_load    = 1'b0;
    w_skid_drain   = 1'b0;
    w_skid_flush   = 1'b0;

    if (w_redirect) begin
      // Redirect overrides everything; same-cycle memory data is dropped.
      w_pc_nxt       = {w_target[31:2], 2'b00};
      w_if_valid_nxt = 1'b0;
      w_skid_flush   = 1'b1;
      w_state_nxt    = FETCH;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (imem_ready) begin
            w_pc_nxt = w_pc4;
            if (!r_if_valid || !stall) begin
              w_if_instr_nxt = imem_rdata;
              w_if_pc4_nxt   = w_pc4;
              w_if_valid_nxt = 1'b1;
            end else begin
              // IR occupied and held: park the word and stop requesting.
              w_skid_load = 1'b1;
              w_state_nxt = FULL;
            end
          end else if (!stall) begin
            w_if_valid_nxt = 1'b0;
          end
        end
        FULL: begin
          if (!stall && w_skid_valid) begin
            w_if_instr_nxt = w_skid_instr;
            w_if_pc4_nxt   = w_skid_pc4;
            w_if_valid_nxt = 1'b1;
            w_skid_drain   = 1'b1;
            w_state_nxt    = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_WORD;
      r_if_pc4   <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
    end
  end

  fetch_skid u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (w_skid_flush),
    .i_instr (imem_rdata),
    .i_pc4   (w_pc4),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc4   (w_skid_pc4)
  );

  assign imem_req  = (r_state == FETCH) && !rst;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  // An empty IR presents a NOP to the decoder.
  assign if_instr  = r_if_valid ? r_if_instr : NOP_WORD;
  assign if_pc4    = r_if_pc4;
  assign op        = if_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  op;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] W0 = 32'h2008_0001;  // addi, op 8
  localparam logic [31:0] W1 = 32'h8C09_0004;  // lw,   op 35
  localparam logic [31:0] W2 = 32'hAC0A_0008;  // sw,   op 43
  localparam logic [31:0] WJ = 32'h0800_0010;  // j 0x40

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc4       (if_pc4),
    .op           (op)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_rdata = 32'h0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_rdata = 32'h0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0;
    #2;
    step();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_valid); else n_pass++;
    n_checks++; if (if_instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", if_instr); else n_pass++;
    n_checks++; if (if_pc4 !== 32'h0) $display("FAIL rst_pc4 got %h exp 0", if_pc4); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL rst_release_req got %b exp 1", imem_req); else n_pass++;
  endtask

  task automatic test_streaming();
    do_reset();
    stall = 1'b0; imem_ready = 1'b1; imem_rdata = W0;
    step();
    n_checks++; if (if_instr !== W0) $display("FAIL stream_i0 got %h exp %h", if_instr, W0); else n_pass++;
    n_checks++; if (if_pc4 !== 32'd4) $display("FAIL stream_pc4_0 got %h exp 4", if_pc4); else n_pass++;
    n_checks++; if (op !== 6'd8) $display("FAIL stream_op0 got %0d exp 8", op); else n_pass++;
    n_checks++; if (imem_addr !== 32'd4) $display("FAIL stream_addr1 got %h exp 4", imem_addr); else n_pass++;
    imem_rdata = W1;
    step();
    n_checks++; if (if_instr !== W1) $display("FAIL stream_i1 got %h exp %h", if_instr, W1); else n_pass++;
    n_checks++; if (if_pc4 !== 32'd8) $display("FAIL stream_pc4_1 got %h exp 8", if_pc4); else n_pass++;
    n_checks++; if (op !== 6'd35) $display("FAIL stream_op1 got %0d exp 35", op); else n_pass++;
    imem_rdata = W2;
    step();
    n_checks++; if (if_instr !== W2) $display("FAIL stream_i2 got %h exp %h", if_instr, W2); else n_pass++;
    n_checks++; if (if_pc4 !== 32'd12) $display("FAIL stream_pc4_2 got %h exp c", if_pc4); else n_pass++;
    n_checks++; if (op !== 6'd43) $display("FAIL stream_op2 got %0d exp 43", op); else n_pass++;
    n_checks++; if (imem_addr !== 32'd12) $display("FAIL stream_addr3 got %h exp c", imem_addr); else n_pass++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    imem_ready = 1'b1; imem_rdata = W0;
    step();
    stall = 1'b1; imem_rdata = W1;
    step();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL skid_req got %b exp 0", imem_req); else n_pass++;
    n_checks++; if (if_instr !== W0) $display("FAIL skid_hold got %h exp %h", if_instr, W0); else n_pass++;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    n_checks++; if (if_instr !== W0) $display("FAIL skid_hold2 got %h exp %h", if_instr, W0); else n_pass++;
    n_checks++; if (imem_addr !== 32'd8) $display("FAIL skid_addr got %h exp 8", imem_addr); else n_pass++;
    stall = 1'b0; imem_ready = 1'b0;
    step();
    n_checks++; if (if_instr !== W1) $display("FAIL skid_drain got %h exp %h", if_instr, W1); else n_pass++;
    n_checks++; if (if_pc4 !== 32'd8) $display("FAIL skid_pc4 got %h exp 8", if_pc4); else n_pass++;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL skid_resume_req got %b exp 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'd8) $display("FAIL skid_resume_addr got %h exp 8", imem_addr); else n_pass++;
    // Next word after drain continues the sequence without loss.
    imem_ready = 1'b1; imem_rdata = W2;
    step();
    n_checks++; if (if_instr !== W2) $display("FAIL skid_next got %h exp %h", if_instr, W2); else n_pass++;
    n_checks++; if (if_pc4 !== 32'd12) $display("FAIL skid_next_pc4 got %h exp c", if_pc4); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b1; imem_rdata = W0;
    step();
    stall = 1'b1; imem_rdata = W1;
    step();
    n_checks++; if (if_valid !== 1'b1) $display("FAIL midrst_pre_valid got %b exp 1", if_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", if_valid); else n_pass++;
    n_checks++; if (if_instr !== 32'h0) $display("FAIL midrst_instr got %h exp 0", if_instr); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL midrst_req got %b exp 0", imem_req); else n_pass++;
    step();
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL midrst_addr got %h exp 0", imem_addr); else n_pass++;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL midrst_req_after got %b exp 1", imem_req); else n_pass++;
  endtask

  task automatic test_jump();
    do_reset();
    imem_ready = 1'b1; imem_rdata = W0;
    step();
    imem_rdata = WJ;
    step();
    n_checks++; if (if_pc4 !== 32'd8) $display("FAIL jump_pre_pc4 got %h exp 8", if_pc4); else n_pass++;
    n_checks++; if (op !== 6'd2) $display("FAIL jump_op got %0d exp 2", op); else n_pass++;
    jump = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    jump = 1'b0;
    n_checks++; if (imem_addr !== 32'h40) $display("FAIL jump_addr got %h exp 40", imem_addr); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL jump_bubble got %b exp 0", if_valid); else n_pass++;
    n_checks++; if (if_instr !== 32'h0) $display("FAIL jump_nop got %h exp 0", if_instr); else n_pass++;
    imem_rdata = W1;
    step();
    n_checks++; if (if_instr !== W1) $display("FAIL jump_land got %h exp %h", if_instr, W1); else n_pass++;
    n_checks++; if (if_pc4 !== 32'h44) $display("FAIL jump_land_pc4 got %h exp 44", if_pc4); else n_pass++;
  endtask

  task automatic test_branch_collision();
    do_reset();
    imem_ready = 1'b1; imem_rdata = WJ;
    step();
    stall = 1'b1; imem_rdata = W1;
    step();
    // Now in FULL with the j in IR; release stall so jump_eff would also fire.
    stall = 1'b0; jump = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103;
    imem_rdata = 32'h2222_2222;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h100) $display("FAIL coll_addr got %h exp 100", imem_addr); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL coll_valid got %b exp 0", if_valid); else n_pass++;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL coll_req got %b exp 1", imem_req); else n_pass++;
    imem_rdata = W2;
    step();
    n_checks++; if (if_instr !== W2) $display("FAIL coll_land got %h exp %h", if_instr, W2); else n_pass++;
    n_checks++; if (if_pc4 !== 32'h104) $display("FAIL coll_pc4 got %h exp 104", if_pc4); else n_pass++;
  endtask

  task automatic test_wait_wrap();
    do_reset();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wait_addr%0d got %h exp fffffffc", i, imem_addr);
      else n_pass++;
      n_checks++;
      if (if_valid !== 1'b0) $display("FAIL wait_valid%0d got %b exp 0", i, if_valid);
      else n_pass++;
    end
    imem_ready = 1'b1; imem_rdata = W0;
    step();
    n_checks++; if (if_pc4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", if_pc4); else n_pass++;
    n_checks++; if (if_instr !== W0) $display("FAIL wrap_instr got %h exp %h", if_instr, W0); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h exp 0", imem_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_reset_mid();
    test_jump();
    test_branch_collision();
    test_wait_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
